// File: rtl/rob_ring.sv
// rob_ring: circular reorder buffer. Allocates in order, captures write-backs out of order,
// retires in order, and flushes on a mispredict at commit. ROB_CDB2_EN adds a second write-back port.
module rob_ring #(
    parameter int ROB_DEPTH = 16,
    parameter int IDX_W     = 4,
    parameter int XLEN      = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,

    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [1:0]       issue_type,
    input  logic [4:0]       issue_rd,
    input  logic [XLEN-1:0]  issue_pc,
    input  logic             issue_pred_tk,
    output logic [IDX_W-1:0] issue_tag,

    input  logic             cdb_valid,
    input  logic [IDX_W-1:0] cdb_tag,
    input  logic [XLEN-1:0]  cdb_value,
    input  logic             cdb_taken,
    input  logic [XLEN-1:0]  cdb_target,
`ifdef ROB_CDB2_EN
    input  logic             cdb2_valid,
    input  logic [IDX_W-1:0] cdb2_tag,
    input  logic [XLEN-1:0]  cdb2_value,
    input  logic             cdb2_taken,
    input  logic [XLEN-1:0]  cdb2_target,
`endif

    input  logic [IDX_W-1:0] qry1_tag,
    input  logic [IDX_W-1:0] qry2_tag,
    output logic             qry1_rdy,
    output logic             qry2_rdy,
    output logic [XLEN-1:0]  qry1_val,
    output logic [XLEN-1:0]  qry2_val,

    output logic             commit_valid,
    input  logic             commit_ready,
    output logic [IDX_W-1:0] commit_tag,
    output logic [1:0]       commit_type,
    output logic [4:0]       commit_rd,
    output logic [XLEN-1:0]  commit_value,

    output logic             flush_out,
    output logic [XLEN-1:0]  flush_pc,
    output logic             rob_empty
);

    typedef enum logic [1:0] {
        OP_STORE  = 2'd0,
        OP_REG    = 2'd1,
        OP_BRANCH = 2'd2,
        OP_JUMP   = 2'd3
    } op_t;

    localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(ROB_DEPTH);

    // Control state: entry validity plus ring pointers.
    logic [ROB_DEPTH-1:0] busy_q;
    logic [ROB_DEPTH-1:0] done_q;
    logic [IDX_W-1:0]     head_q;
    logic [IDX_W-1:0]     tail_q;
    logic [IDX_W:0]       count_q;

    // Payload state, only meaningful where busy_q/done_q say so.
    op_t                  type_q [ROB_DEPTH];
    logic [4:0]           rd_q   [ROB_DEPTH];
    logic [XLEN-1:0]      pc_q   [ROB_DEPTH];
    logic [XLEN-1:0]      val_q  [ROB_DEPTH];
    logic [XLEN-1:0]      tgt_q  [ROB_DEPTH];
    logic [ROB_DEPTH-1:0] pred_q;
    logic [ROB_DEPTH-1:0] taken_q;

    logic            full;
    logic            retire;
    logic            mispredict;
    logic            flush;
    logic            do_issue;
    logic            cdb_hit;
    logic [XLEN-1:0] head_seq_pc;

    assign full        = (count_q == FULL_CNT);
    assign issue_ready = rdy_in && !full;
    assign issue_tag   = tail_q;
    assign rob_empty   = (count_q == '0);

    assign commit_valid = rdy_in && busy_q[head_q] && done_q[head_q];
    assign retire       = commit_valid && commit_ready;
    assign head_seq_pc  = pc_q[head_q] + XLEN'(4);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        mispredict = 1'b0;
        case (type_q[head_q])
            OP_BRANCH: mispredict = (taken_q[head_q] != pred_q[head_q]);
            OP_JUMP:   mispredict = pred_q[head_q] ? !taken_q[head_q]
                                                   : (tgt_q[head_q] != head_seq_pc);
            default:   mispredict = 1'b0;
        endcase
    end

    assign flush     = retire && mispredict;
    assign flush_out = flush;
    assign flush_pc  = !flush          ? '0 :
                       taken_q[head_q] ? tgt_q[head_q] : head_seq_pc;

    // A flushing retire discards everything else that happens in the same cycle.
    assign do_issue = issue_valid && issue_ready && !flush;
    assign cdb_hit  = rdy_in && !flush && cdb_valid && busy_q[cdb_tag];

`ifdef ROB_CDB2_EN
    logic cdb2_hit;
    assign cdb2_hit = rdy_in && !flush && cdb2_valid && busy_q[cdb2_tag];
`endif

    assign commit_tag   = commit_valid ? head_q         : '0;
    assign commit_type  = commit_valid ? type_q[head_q] : 2'd0;
    assign commit_rd    = commit_valid ? rd_q[head_q]   : '0;
    assign commit_value = commit_valid ? val_q[head_q]  : '0;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            busy_q  <= '0;
            done_q  <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
                busy_q  <= '0;
                done_q  <= '0;
            end else begin
`ifdef ROB_CDB2_EN
                if (cdb2_hit) done_q[cdb2_tag] <= 1'b1;
`endif
                if (cdb_hit) done_q[cdb_tag] <= 1'b1;
                if (do_issue) begin
                    busy_q[tail_q] <= 1'b1;
                    done_q[tail_q] <= 1'b0;
                    tail_q         <= tail_q + 1'b1;
                end
                if (retire) begin
                    busy_q[head_q] <= 1'b0;
                    done_q[head_q] <= 1'b0;
                    head_q         <= head_q + 1'b1;
                end
                case ({do_issue, retire})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // NOTE: payload arrays are not reset; busy_q/done_q gate every use, which keeps them plain RAM.
    always_ff @(posedge clk_in) begin
        if (do_issue) begin
            type_q[tail_q] <= op_t'(issue_type);
            rd_q[tail_q]   <= issue_rd;
            pc_q[tail_q]   <= issue_pc;
            pred_q[tail_q] <= issue_pred_tk;
        end
`ifdef ROB_CDB2_EN
        if (cdb2_hit) begin
            val_q[cdb2_tag]   <= cdb2_value;
            taken_q[cdb2_tag] <= cdb2_taken;
            tgt_q[cdb2_tag]   <= cdb2_target;
        end
`endif
        // Port 1 is written last so it wins a same-tag collision.
        if (cdb_hit) begin
            val_q[cdb_tag]   <= cdb_value;
            taken_q[cdb_tag] <= cdb_taken;
            tgt_q[cdb_tag]   <= cdb_target;
        end
    end

    // Operand lookup: live write-back bypass first, then stored result.
    always_comb begin
        qry1_rdy = busy_q[qry1_tag] && done_q[qry1_tag];
        qry1_val = qry1_rdy ? val_q[qry1_tag] : '0;
        qry2_rdy = busy_q[qry2_tag] && done_q[qry2_tag];
        qry2_val = qry2_rdy ? val_q[qry2_tag] : '0;
`ifdef ROB_CDB2_EN
        if (cdb2_valid && cdb2_tag == qry1_tag) begin
            qry1_rdy = 1'b1;
            qry1_val = cdb2_value;
        end
        if (cdb2_valid && cdb2_tag == qry2_tag) begin
            qry2_rdy = 1'b1;
            qry2_val = cdb2_value;
        end
`endif
        if (cdb_valid && cdb_tag == qry1_tag) begin
            qry1_rdy = 1'b1;
            qry1_val = cdb_value;
        end
        if (cdb_valid && cdb_tag == qry2_tag) begin
            qry2_rdy = 1'b1;
            qry2_val = cdb_value;
        end
    end

endmodule

// File: tb/tb_rob_ring.sv
// Directed bench for rob_ring: reset, fill/drain, wrap, mispredict flush, commit stall, freeze.
module tb_rob_ring;
    localparam int ROB_DEPTH = 16;
    localparam int IDX_W     = 4;
    localparam int XLEN      = 32;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic             rdy_in;
    logic             issue_valid;
    logic             issue_ready;
    logic [1:0]       issue_type;
    logic [4:0]       issue_rd;
    logic [XLEN-1:0]  issue_pc;
    logic             issue_pred_tk;
    logic [IDX_W-1:0] issue_tag;
    logic             cdb_valid;
    logic [IDX_W-1:0] cdb_tag;
    logic [XLEN-1:0]  cdb_value;
    logic             cdb_taken;
    logic [XLEN-1:0]  cdb_target;
`ifdef ROB_CDB2_EN
    logic             cdb2_valid;
    logic [IDX_W-1:0] cdb2_tag;
    logic [XLEN-1:0]  cdb2_value;
    logic             cdb2_taken;
    logic [XLEN-1:0]  cdb2_target;
`endif
    logic [IDX_W-1:0] qry1_tag, qry2_tag;
    logic             qry1_rdy, qry2_rdy;
    logic [XLEN-1:0]  qry1_val, qry2_val;
    logic             commit_valid;
    logic             commit_ready;
    logic [IDX_W-1:0] commit_tag;
    logic [1:0]       commit_type;
    logic [4:0]       commit_rd;
    logic [XLEN-1:0]  commit_value;
    logic             flush_out;
    logic [XLEN-1:0]  flush_pc;
    logic             rob_empty;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk_in = ~clk_in;

    rob_ring #(.ROB_DEPTH(ROB_DEPTH), .IDX_W(IDX_W), .XLEN(XLEN)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_type(issue_type),
        .issue_rd(issue_rd), .issue_pc(issue_pc), .issue_pred_tk(issue_pred_tk),
        .issue_tag(issue_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .cdb_taken(cdb_taken), .cdb_target(cdb_target),
`ifdef ROB_CDB2_EN
        .cdb2_valid(cdb2_valid), .cdb2_tag(cdb2_tag), .cdb2_value(cdb2_value),
        .cdb2_taken(cdb2_taken), .cdb2_target(cdb2_target),
`endif
        .qry1_tag(qry1_tag), .qry2_tag(qry2_tag), .qry1_rdy(qry1_rdy), .qry2_rdy(qry2_rdy),
        .qry1_val(qry1_val), .qry2_val(qry2_val),
        .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_tag(commit_tag),
        .commit_type(commit_type), .commit_rd(commit_rd), .commit_value(commit_value),
        .flush_out(flush_out), .flush_pc(flush_pc), .rob_empty(rob_empty)
    );

    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        issue_valid   = 1'b0;
        issue_type    = 2'd0;
        issue_rd      = 5'd0;
        issue_pc      = '0;
        issue_pred_tk = 1'b0;
        cdb_valid     = 1'b0;
        cdb_tag       = '0;
        cdb_value     = '0;
        cdb_taken     = 1'b0;
        cdb_target    = '0;
`ifdef ROB_CDB2_EN
        cdb2_valid    = 1'b0;
        cdb2_tag      = '0;
        cdb2_value    = '0;
        cdb2_taken    = 1'b0;
        cdb2_target   = '0;
`endif
        qry1_tag      = '0;
        qry2_tag      = '0;
        commit_ready  = 1'b0;
    endtask

    task automatic set_issue(input logic [1:0] t, input logic [4:0] rd,
                             input logic [XLEN-1:0] pc, input logic pred);
        issue_valid   = 1'b1;
        issue_type    = t;
        issue_rd      = rd;
        issue_pc      = pc;
        issue_pred_tk = pred;
    endtask

    task automatic set_cdb(input logic [IDX_W-1:0] tag, input logic [XLEN-1:0] value,
                           input logic taken, input logic [XLEN-1:0] target);
        cdb_valid  = 1'b1;
        cdb_tag    = tag;
        cdb_value  = value;
        cdb_taken  = taken;
        cdb_target = target;
    endtask

    // Pulse reset between negedges; state is clean at the next cycle.
    task automatic pulse_reset();
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Each cycle: drive right after negedge, check at #1, advance with @(negedge).
    initial begin
        rst_in = 1'b1;
        rdy_in = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk_in);
        #1;
        check("rst_issue_ready", issue_ready, 1);
        check("rst_issue_tag", issue_tag, 0);
        check("rst_rob_empty", rob_empty, 1);
        check("rst_commit_valid", commit_valid, 0);
        check("rst_commit_value", commit_value, 0);
        check("rst_flush_out", flush_out, 0);
        check("rst_flush_pc", flush_pc, 0);
        check("rst_qry1_rdy", qry1_rdy, 0);
        check("rst_qry1_val", qry1_val, 0);
        @(negedge clk_in);
        rst_in = 1'b0;

        // 1: reset with 5 entries busy, head ready
        for (int i = 0; i < 5; i++) begin
            set_issue(2'd1, 5'(i + 1), 32'h40 + 32'(4 * i), 1'b0);
            #1 check($sformatf("t1_issue_tag[%0d]", i), issue_tag, i);
            @(negedge clk_in);
        end
        issue_valid = 1'b0;
        set_cdb(4'd0, 32'h77, 1'b0, 32'h0);
        #1 check("t1_not_empty", rob_empty, 0);
        @(negedge clk_in);
        cdb_valid = 1'b0;
        #1 check("t1_head_valid", commit_valid, 1);
        rst_in = 1'b1;
        #1;
        check("t1_rst_empty", rob_empty, 1);
        check("t1_rst_commit_valid", commit_valid, 0);
        check("t1_rst_issue_tag", issue_tag, 0);
        check("t1_rst_qry_rdy", qry1_rdy, 0);
        @(negedge clk_in);
        rst_in = 1'b0;
        #1 check("t1_rel_issue_tag", issue_tag, 0);
        check("t1_rel_empty", rob_empty, 1);
        @(negedge clk_in);

        // 2: fill 16, write back in reverse, drain in order
        for (int i = 0; i < 16; i++) begin
            set_issue(2'd1, 5'(i + 1), 32'h100 + 32'(4 * i), 1'b0);
            #1 check($sformatf("t2_issue_tag[%0d]", i), issue_tag, i);
            check($sformatf("t2_issue_ready[%0d]", i), issue_ready, 1);
            @(negedge clk_in);
        end
        issue_valid = 1'b0;
        #1 check("t2_full_ready", issue_ready, 0);
        check("t2_full_empty", rob_empty, 0);
        @(negedge clk_in);
        qry1_tag = 4'd15;
        for (int j = 15; j >= 0; j--) begin
            set_cdb(4'(j), 32'hA000 + 32'(j), 1'b0, 32'h0);
            qry2_tag = 4'(j);
            #1 check($sformatf("t2_byp_rdy[%0d]", j), qry2_rdy, 1);
            check($sformatf("t2_byp_val[%0d]", j), qry2_val, 32'hA000 + 32'(j));
            check($sformatf("t2_no_commit[%0d]", j), commit_valid, 0);
            if (j == 0) begin
                check("t2_stored_rdy", qry1_rdy, 1);
                check("t2_stored_val", qry1_val, 32'hA00F);
            end
            @(negedge clk_in);
        end
        cdb_valid    = 1'b0;
        commit_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 0) set_issue(2'd1, 5'd9, 32'h900, 1'b0);
            else issue_valid = 1'b0;
            #1 check($sformatf("t2_cv[%0d]", i), commit_valid, 1);
            check($sformatf("t2_ctag[%0d]", i), commit_tag, i);
            check($sformatf("t2_cval[%0d]", i), commit_value, 32'hA000 + 32'(i));
            check($sformatf("t2_crd[%0d]", i), commit_rd, i + 1);
            if (i == 0) check("t2_full_commit_ready", issue_ready, 0);
            @(negedge clk_in);
        end
        issue_valid = 1'b0;
        #1 check("t2_drained_empty", rob_empty, 1);
        check("t2_drained_cv", commit_valid, 0);
        @(negedge clk_in);

        // 3: 20 ops pipelined issue->cdb->commit, tags wrap 15->0
        for (int k = 0; k < 22; k++) begin
            if (k < 20) set_issue(2'd1, 5'(k % 16 + 1), 32'h500 + 32'(4 * k), 1'b0);
            else issue_valid = 1'b0;
            if (k >= 1 && k <= 20) set_cdb(4'((k - 1) % 16), 32'hB000 + 32'(k - 1), 1'b0, 32'h0);
            else cdb_valid = 1'b0;
            qry1_tag = 4'((k + 15) % 16);
            #1;
            if (k < 20) check($sformatf("t3_issue_tag[%0d]", k), issue_tag, k % 16);
            if (k >= 1 && k <= 20) begin
                check($sformatf("t3_byp_rdy[%0d]", k), qry1_rdy, 1);
                check($sformatf("t3_byp_val[%0d]", k), qry1_val, 32'hB000 + 32'(k - 1));
            end
            check($sformatf("t3_cv[%0d]", k), commit_valid, (k >= 2) ? 1 : 0);
            if (k >= 2) begin
                check($sformatf("t3_ctag[%0d]", k), commit_tag, (k - 2) % 16);
                check($sformatf("t3_cval[%0d]", k), commit_value, 32'hB000 + 32'(k - 2));
            end
            @(negedge clk_in);
        end
        idle_inputs();
        #1 check("t3_empty", rob_empty, 1);
        pulse_reset();

        // 4: branch mispredict at tag 3 flushes tags 4..7
        for (int i = 0; i < 8; i++) begin
            case (i)
                1:       set_issue(2'd2, 5'd0, 32'h204, 1'b1);
                2:       set_issue(2'd3, 5'd2, 32'h208, 1'b0);
                3:       set_issue(2'd2, 5'd0, 32'h20C, 1'b0);
                default: set_issue(2'd1, 5'(i), 32'h200 + 32'(4 * i), 1'b0);
            endcase
            @(negedge clk_in);
        end
        issue_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            case (i)
                1:       set_cdb(4'd1, 32'h0, 1'b1, 32'h300);
                2:       set_cdb(4'd2, 32'h20C, 1'b1, 32'h20C);
                3:       set_cdb(4'd3, 32'h0, 1'b1, 32'h1000);
                default: set_cdb(4'(i), 32'hC000 + 32'(i), 1'b0, 32'h0);
            endcase
            @(negedge clk_in);
        end
        cdb_valid    = 1'b0;
        commit_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("t4_ctag[%0d]", i), commit_tag, i);
            check($sformatf("t4_noflush[%0d]", i), flush_out, 0);
            @(negedge clk_in);
        end
        set_issue(2'd1, 5'd7, 32'h700, 1'b0);
        set_cdb(4'd6, 32'hDEAD, 1'b0, 32'h0);
        #1 check("t4_br_ctag", commit_tag, 3);
        check("t4_flush_out", flush_out, 1);
        check("t4_flush_pc", flush_pc, 32'h1000);
        @(negedge clk_in);
        idle_inputs();
        commit_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("t4_post_empty[%0d]", i), rob_empty, 1);
            check($sformatf("t4_post_cv[%0d]", i), commit_valid, 0);
            check($sformatf("t4_post_flush[%0d]", i), flush_out, 0);
            check($sformatf("t4_post_tag[%0d]", i), issue_tag, 0);
            @(negedge clk_in);
        end

        // 5: store head stalled by commit_ready, then rdy_in freeze
        commit_ready = 1'b0;
        set_issue(2'd0, 5'd3, 32'h400, 1'b0);
        @(negedge clk_in);
        issue_valid = 1'b0;
        set_cdb(4'd9, 32'h99, 1'b0, 32'h0);
        @(negedge clk_in);
        set_cdb(4'd0, 32'h55, 1'b0, 32'h0);
        qry2_tag = 4'd9;
        #1 check("t5_nonbusy_ignored", qry2_rdy, 0);
        @(negedge clk_in);
        cdb_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("t5_stall_cv[%0d]", i), commit_valid, 1);
            check($sformatf("t5_stall_tag[%0d]", i), commit_tag, 0);
            check($sformatf("t5_stall_type[%0d]", i), commit_type, 0);
            check($sformatf("t5_stall_val[%0d]", i), commit_value, 32'h55);
            @(negedge clk_in);
        end
        rdy_in       = 1'b0;
        commit_ready = 1'b1;
        set_issue(2'd1, 5'd4, 32'h404, 1'b0);
        for (int i = 0; i < 2; i++) begin
            #1 check($sformatf("t5_frz_cv[%0d]", i), commit_valid, 0);
            check($sformatf("t5_frz_ready[%0d]", i), issue_ready, 0);
            check($sformatf("t5_frz_flush[%0d]", i), flush_out, 0);
            @(negedge clk_in);
        end
        rdy_in       = 1'b1;
        issue_valid  = 1'b0;
        commit_ready = 1'b0;
        #1 check("t5_thaw_cv", commit_valid, 1);
        check("t5_thaw_tag", commit_tag, 0);
        check("t5_thaw_issue_tag", issue_tag, 1);
        @(negedge clk_in);
        commit_ready = 1'b1;
        #1 check("t5_retire_cv", commit_valid, 1);
        @(negedge clk_in);
        commit_ready = 1'b0;
        #1 check("t5_final_empty", rob_empty, 1);

`ifdef ROB_CDB2_EN
        // 6: dual write-back ports
        pulse_reset();
        for (int i = 0; i < 6; i++) begin
            set_issue(2'd1, 5'(i + 1), 32'h600 + 32'(4 * i), 1'b0);
            @(negedge clk_in);
        end
        issue_valid = 1'b0;
        set_cdb(4'd2, 32'h22, 1'b0, 32'h0);
        cdb2_valid = 1'b1;
        cdb2_tag   = 4'd5;
        cdb2_value = 32'h55;
        @(negedge clk_in);
        set_cdb(4'd3, 32'h31, 1'b0, 32'h0);
        cdb2_tag   = 4'd3;
        cdb2_value = 32'h32;
        qry1_tag   = 4'd3;
        qry2_tag   = 4'd2;
        #1 check("t6_byp_p1_wins", qry1_val, 32'h31);
        check("t6_tag2_rdy", qry2_rdy, 1);
        check("t6_tag2_val", qry2_val, 32'h22);
        @(negedge clk_in);
        cdb_valid  = 1'b0;
        cdb2_valid = 1'b0;
        qry2_tag   = 4'd5;
        #1 check("t6_tag3_rdy", qry1_rdy, 1);
        check("t6_tag3_val", qry1_val, 32'h31);
        check("t6_tag5_rdy", qry2_rdy, 1);
        check("t6_tag5_val", qry2_val, 32'h55);
        @(negedge clk_in);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
